// File: rtl/axi4_pkg.sv
// Shared AXI4 constants, the issue-FSM state type and the AxSIZE helper
// for the burst master.
package axi4_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AW    = 2'd1,
    ST_WDATA = 2'd2,
    ST_AR    = 2'd3
  } issue_state_e;

  // Bytes-per-beat encoding: full-width beats only.
  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi4_burst_master_if.sv
// Command/payload side and AXI4 side of the burst master bundled as one
// interface; master is the DUT view, slave the environment view.
interface axi4_burst_master_if #(
  parameter int data_width = 32,
  parameter int addr_width = 32,
  parameter int id_width   = 4
);

  logic                    CMD_VALID;
  logic                    CMD_READY;
  logic                    CMD_WRITE;
  logic [addr_width-1:0]   CMD_ADDR;
  logic [7:0]              CMD_LEN;
  logic [id_width-1:0]     CMD_ID;

  logic                    WD_VALID;
  logic                    WD_READY;
  logic [data_width-1:0]   WD_DATA;
  logic [data_width/8-1:0] WD_STRB;

  logic                    RD_VALID;
  logic                    RD_READY;
  logic [data_width-1:0]   RD_DATA;
  logic                    RD_LAST;
  logic [1:0]              RD_RESP;
  logic [id_width-1:0]     RD_ID;

  logic                    BR_VALID;
  logic [1:0]              BR_RESP;
  logic [id_width-1:0]     BR_ID;

  logic                    AWVALID;
  logic                    AWREADY;
  logic [addr_width-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic [id_width-1:0]     AWID;

  logic                    WVALID;
  logic                    WREADY;
  logic [data_width-1:0]   WDATA;
  logic [data_width/8-1:0] WSTRB;
  logic                    WLAST;

  logic                    BVALID;
  logic                    BREADY;
  logic [1:0]              BRESP;
  logic [id_width-1:0]     BID;

  logic                    ARVALID;
  logic                    ARREADY;
  logic [addr_width-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic [id_width-1:0]     ARID;

  logic                    RVALID;
  logic                    RREADY;
  logic [data_width-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic [id_width-1:0]     RID;
  logic                    RLAST;

  logic                    ERR;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_LEN, CMD_ID,
    output CMD_READY,
    input  WD_VALID, WD_DATA, WD_STRB,
    output WD_READY,
    input  RD_READY,
    output RD_VALID, RD_DATA, RD_LAST, RD_RESP, RD_ID,
    output BR_VALID, BR_RESP, BR_ID,
    output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID,
    input  AWREADY,
    output WVALID, WDATA, WSTRB, WLAST,
    input  WREADY,
    input  BVALID, BRESP, BID,
    output BREADY,
    output ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARID,
    input  ARREADY,
    input  RVALID, RDATA, RRESP, RID, RLAST,
    output RREADY,
    output ERR
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_LEN, CMD_ID,
    input  CMD_READY,
    output WD_VALID, WD_DATA, WD_STRB,
    input  WD_READY,
    output RD_READY,
    input  RD_VALID, RD_DATA, RD_LAST, RD_RESP, RD_ID,
    input  BR_VALID, BR_RESP, BR_ID,
    input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID,
    output AWREADY,
    input  WVALID, WDATA, WSTRB, WLAST,
    output WREADY,
    output BVALID, BRESP, BID,
    input  BREADY,
    input  ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARID,
    output ARREADY,
    output RVALID, RDATA, RRESP, RID, RLAST,
    input  RREADY,
    input  ERR
  );

endinterface

// File: rtl/axi4_outstanding_ctr.sv
// Up/down count of bursts in flight for one direction; full blocks new
// commands once max_outstanding bursts are open.
module axi4_outstanding_ctr #(
  parameter int max_outstanding = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Simultaneous inc and dec cancel; the guards only matter for a
  // misbehaving slave returning more responses than requests.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != 4'hF)) begin
      cnt_d = cnt_q + 4'd1;
    end else if (dec && !inc && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full = (cnt_q >= 4'(max_outstanding));

endmodule

// File: rtl/axi4_burst_master.sv
// Single-issue AXI4 INCR burst master: one command at a time on AW/W or AR,
// with responses streamed back and outstanding bursts bounded per direction.
module axi4_burst_master
  import axi4_pkg::*;
#(
  parameter int data_width      = 32,
  parameter int addr_width      = 32,
  parameter int id_width        = 4,
  parameter int max_outstanding = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  axi4_burst_master_if.master  bus
);

  localparam logic [2:0] AXSIZE = axi_size(data_width);

  issue_state_e          state_q;
  logic                  run_q;
  logic                  aw_valid_q;
  logic [addr_width-1:0] aw_addr_q;
  logic [7:0]            aw_len_q;
  logic [id_width-1:0]   aw_id_q;
  logic                  ar_valid_q;
  logic [addr_width-1:0] ar_addr_q;
  logic [7:0]            ar_len_q;
  logic [id_width-1:0]   ar_id_q;
  logic [7:0]            beat_q;
  logic                  br_valid_q;
  logic [1:0]            br_resp_q;
  logic [id_width-1:0]   br_id_q;
  logic                  err_q;

  logic wr_full;
  logic rd_full;
  logic sel_full;
  logic cmd_ready;
  logic cmd_hs;
  logic aw_hs;
  logic ar_hs;
  logic w_active;
  logic w_last;
  logic w_hs;
  logic b_hs;
  logic r_hs;
  logic r_done;
  logic err_set;

  // run_q holds BREADY/CMD_READY low until the first edge out of reset.
  assign sel_full  = bus.CMD_WRITE ? wr_full : rd_full;
  assign cmd_ready = run_q && (state_q == ST_IDLE) && !sel_full;
  assign cmd_hs    = bus.CMD_VALID && cmd_ready;
  assign aw_hs     = aw_valid_q && bus.AWREADY;
  assign ar_hs     = ar_valid_q && bus.ARREADY;
  assign w_active  = (state_q == ST_WDATA);
  assign w_last    = w_active && (beat_q == aw_len_q);
  assign w_hs      = w_active && bus.WD_VALID && bus.WREADY;
  assign b_hs      = bus.BVALID && run_q;
  assign r_hs      = bus.RVALID && bus.RD_READY;
  assign r_done    = r_hs && bus.RLAST;
  assign err_set   = (b_hs && (bus.BRESP != AXI_RESP_OKAY)) ||
                     (r_hs && (bus.RRESP != AXI_RESP_OKAY));

  axi4_outstanding_ctr #(.max_outstanding(max_outstanding)) u_wr_ctr (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .inc   (aw_hs),
    .dec   (b_hs),
    .full  (wr_full)
  );

  axi4_outstanding_ctr #(.max_outstanding(max_outstanding)) u_rd_ctr (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .inc   (ar_hs),
    .dec   (r_done),
    .full  (rd_full)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q    <= ST_IDLE;
      run_q      <= 1'b0;
      aw_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_id_q    <= '0;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_id_q    <= '0;
      beat_q     <= '0;
      br_valid_q <= 1'b0;
      br_resp_q  <= '0;
      br_id_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      br_valid_q <= b_hs;
      if (b_hs) begin
        br_resp_q <= bus.BRESP;
        br_id_q   <= bus.BID;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (cmd_hs) begin
            if (bus.CMD_WRITE) begin
              state_q    <= ST_AW;
              aw_valid_q <= 1'b1;
              aw_addr_q  <= bus.CMD_ADDR;
              aw_len_q   <= bus.CMD_LEN;
              aw_id_q    <= bus.CMD_ID;
            end else begin
              state_q    <= ST_AR;
              ar_valid_q <= 1'b1;
              ar_addr_q  <= bus.CMD_ADDR;
              ar_len_q   <= bus.CMD_LEN;
              ar_id_q    <= bus.CMD_ID;
            end
          end
        end
        ST_AW: begin
          if (aw_hs) begin
            aw_valid_q <= 1'b0;
            beat_q     <= '0;
            state_q    <= ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (w_hs) begin
            if (w_last) begin
              state_q <= ST_IDLE;
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        ST_AR: begin
          if (ar_hs) begin
            ar_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.CMD_READY = cmd_ready;

  assign bus.AWVALID   = aw_valid_q;
  assign bus.AWADDR    = aw_addr_q;
  assign bus.AWLEN     = aw_len_q;
  assign bus.AWSIZE    = AXSIZE;
  assign bus.AWBURST   = AXI_BURST_INCR;
  assign bus.AWID      = aw_id_q;

  // Write payload is a straight pass-through, qualified only by state.
  assign bus.WVALID    = w_active && bus.WD_VALID;
  assign bus.WD_READY  = w_active && bus.WREADY;
  assign bus.WDATA     = bus.WD_DATA;
  assign bus.WSTRB     = bus.WD_STRB;
  assign bus.WLAST     = w_last;

  assign bus.BREADY    = run_q;
  assign bus.BR_VALID  = br_valid_q;
  assign bus.BR_RESP   = br_resp_q;
  assign bus.BR_ID     = br_id_q;

  assign bus.ARVALID   = ar_valid_q;
  assign bus.ARADDR    = ar_addr_q;
  assign bus.ARLEN     = ar_len_q;
  assign bus.ARSIZE    = AXSIZE;
  assign bus.ARBURST   = AXI_BURST_INCR;
  assign bus.ARID      = ar_id_q;

  assign bus.RREADY    = bus.RD_READY;
  assign bus.RD_VALID  = bus.RVALID;
  assign bus.RD_DATA   = bus.RDATA;
  assign bus.RD_LAST   = bus.RLAST;
  assign bus.RD_RESP   = bus.RRESP;
  assign bus.RD_ID     = bus.RID;

  assign bus.ERR       = err_q;

endmodule

// File: doc/axi4_burst_master.md
AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master

Interface
REQ-001 Parameters SHALL be:
- data_width, 32: data bus width, 32..1024, power of 2.
- addr_width, 32: address width.
- id_width, 4: AWID/ARID/BID/RID width.
- max_outstanding, 4: outstanding bursts per direction, 1..15.
REQ-002 ACLK  in  1  single clock; all logic on rising edge.
REQ-003 ARESETn  in  1  reset; synchronous, active-low.
REQ-004 CMD_VALID/CMD_READY  in/out  1/1  command handshake.
REQ-005 CMD_WRITE, CMD_ADDR, CMD_LEN, CMD_ID  in  1/addr_width/8/id_width  direction, byte address, beats-1, transaction id.
REQ-006 WD_VALID/WD_READY, WD_DATA, WD_STRB  in/out, in, in  1/1, data_width, data_width/8  write payload stream.
REQ-007 RD_VALID/RD_READY, RD_DATA, RD_LAST, RD_RESP, RD_ID  out/in, out...  1/1, data_width, 1, 2, id_width  read return stream.
REQ-008 BR_VALID, BR_RESP, BR_ID  out  1, 2, id_width  write-response pulse.
REQ-009 AW*: AWVALID out, AWREADY in, AWADDR, AWLEN[7:0], AWSIZE[2:0], AWBURST[1:0], AWID out.
REQ-010 W*: WVALID out, WREADY in, WDATA, WSTRB, WLAST out.
REQ-011 B*: BVALID in, BREADY out, BRESP[1:0], BID in.
REQ-012 AR*: ARVALID out, ARREADY in, ARADDR, ARLEN, ARSIZE, ARBURST, ARID out.
REQ-013 R*: RVALID in, RREADY out, RDATA, RRESP, RID, RLAST in.
REQ-014 ERR  out  1  sticky: any BRESP/RRESP != OKAY.

Function
REQ-015 Issue FSM states SHALL be IDLE, AW, WDATA, AR.
REQ-016 CMD_READY SHALL be 1 only in IDLE and when the selected direction's outstanding count < max_outstanding.
REQ-017 On CMD handshake, IDLE SHALL go to AW (write) or AR (read), registering address/len/id into AW*/AR* with VALID=1 next cycle.
REQ-018 AWVALID/ARVALID SHALL hold with stable payload until READY; AW->WDATA, AR->IDLE on handshake.
REQ-019 AWSIZE/ARSIZE SHALL equal log2(data_width/8); AWBURST/ARBURST SHALL be INCR (2'b01).
REQ-020 In WDATA: WVALID=WD_VALID, WD_READY=WREADY, WDATA/WSTRB pass through combinationally; beat counter counts W handshakes; WLAST=1 when counter==AWLEN; WLAST handshake -> IDLE; WD_READY=0 outside WDATA.
REQ-021 Write outstanding counter SHALL +1 on AW handshake, -1 on B handshake, unchanged if both in one cycle; read counter likewise on AR handshake and R handshake with RLAST.
REQ-022 BREADY SHALL be constant 1 out of reset; BR_VALID/BR_RESP/BR_ID SHALL be registered, one-cycle pulse one cycle after each B handshake.
REQ-023 RREADY=RD_READY; RD_* = RVALID/RDATA/RLAST/RRESP/RID, combinational, zero latency.
REQ-024 ERR SHALL set on B handshake with BRESP!=0 or R handshake with RRESP!=0; cleared only by reset.
REQ-025 CMD_LEN+1 beats SHALL equal AWLEN/ARLEN+1; LEN=0 single-beat WLAST on first beat.

Reset
REQ-026 While ARESETn=0 at an edge: state IDLE, AWVALID, WVALID, ARVALID, BREADY, BR_VALID, ERR, CMD_READY, counters, beat counter all 0; AW*/AR* payload 0.
REQ-027 Reset mid-burst SHALL abandon the transaction; no completion reported.
REQ-028 BREADY and CMD_READY SHALL rise no earlier than the first edge after ARESETn=1.

Structure
REQ-029 Package axi4_pkg SHALL hold AXI_BURST_INCR, AXI_RESP_OKAY/SLVERR/DECERR constants and the issue-state enumeration.
REQ-030 One sub-module axi4_outstanding_ctr (up/down counter, full flag, parameter max) SHALL be instantiated twice.

Verification
REQ-031 Write LEN=3 at 0x1000, AWREADY=1, WREADY=1 -> AWADDR=0x1000, AWLEN=3, 4 W beats, WLAST on 4th; BRESP=0 -> BR_VALID pulse, ERR=0.
REQ-032 Read LEN=0, RRESP=2 -> RD_RESP=2, RD_LAST=1, ERR=1 sticky until reset.
REQ-033 max_outstanding=2, BVALID held 0, three writes -> third CMD_READY=0 until one B handshake.
REQ-034 B and AW handshakes in same cycle at count 1 -> count stays 1.
REQ-035 AWREADY low 5 cycles -> AWVALID/AWADDR stable throughout.
REQ-036 ARESETn=0 during WDATA beat 2 of 4 -> next cycle WVALID=0, state IDLE, counters 0, BR_VALID never asserted.
